// File: rtl/processor_pkg.sv
// Shared processor definitions: arbiter state encoding
// and default ownership hold limit.
package processor_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_GRANT = 2'd1;
  localparam arb_state_t ST_TURN  = 2'd2;

  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Cyclic priority search: first set request at or
// above the pointer, wrapping around.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [PW-1:0]    win_o,
  output logic             any_o
);

  int idx;

  // Descending scan so the smallest offset wins last.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (req_i[idx]) begin
        win_o = PW'(idx);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared tri-state bus
// with hold limit and one-cycle turnaround.
module bus_arbiter
  import processor_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     owner_valid,
  output logic                     bus_output_enable,
  output logic                     timeout
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_HOLD + 1);

  arb_state_t state_q, state_d;

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;

  logic [PW-1:0] win;
  logic          any;
  logic          rel;
  logic          lim;
  logic          leave;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any)
  );

  assign rel   = done[owner_q] | ~req[owner_q];
  assign lim   = (cnt_q == CW'(MAX_HOLD));
  assign leave = rel | lim;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_GRANT): begin
        state_d = leave ? ST_TURN : ST_GRANT;
      end
      default: begin
        state_d = any ? ST_GRANT : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tout_d  = 1'b0;
    unique case (1'b1)
      (state_q == ST_GRANT): begin
        if (leave) begin
          grant_d = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          // A release at the limit edge is not a timeout.
          tout_d  = lim & ~rel;
          if (owner_q == PW'(N_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = owner_q + PW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (any) begin
          grant_d[win] = 1'b1;
          owner_d      = win;
          valid_d      = 1'b1;
          cnt_d        = CW'(1);
        end
      end
    endcase
  end

  assign grant             = grant_q;
  assign owner             = owner_q;
  assign owner_valid       = valid_q;
  assign bus_output_enable = valid_q;
  assign timeout           = tout_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the processor's shared 16-bit tri-state `bus`, granting it to one of `N_REQ` requesters (register-file readout, debug port, future I/O masters) at a time. Grants are one-hot and held until the owner releases or a hold limit expires. A mandatory one-cycle turnaround with no driver separates consecutive owners, so two sources never drive `bus` in the same cycle. Sits beside `control_unit`; its `bus_output_enable` output gates the tri-state driver of the granted source.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership (≥2).
- `clock` input 1: single clock; all state changes on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `req` input N_REQ: per-requester bus request, level-sensitive.
- `done` input N_REQ: per-requester release strobe; only the owner's bit is honoured.
- `grant` output N_REQ: registered one-hot grant, all-zero when no owner.
- `owner` output $clog2(N_REQ): index of current owner; holds last owner when idle.
- `owner_valid` output 1: high while `grant` is non-zero.
- `bus_output_enable` output 1: equals `owner_valid`; drives the tri-state enable.
- `timeout` output 1: one-cycle pulse when an ownership is ended by the hold limit.

## Operation
- States: IDLE, GRANT, TURN.
- Reset (async, any state): state=IDLE, `grant`=0, `owner`=0, `owner_valid`=0, `bus_output_enable`=0, `timeout`=0, round-robin pointer=0, hold counter=0.
- Arbitration (in IDLE or TURN): winner is the first set `req` bit searching upward cyclically from pointer. If none, go/stay IDLE. Otherwise next state GRANT, `grant` one-hot at winner, `owner`=winner, hold counter=1.
- GRANT: hold counter increments each cycle. Exit to TURN at the edge where any of:
  - `done[owner]`=1, or
  - `req[owner]`=0, or
  - hold counter==MAX_HOLD (timeout).
- On exit: `grant`=0, `owner_valid`=0, pointer=(owner+1) mod N_REQ. `timeout`=1 during TURN only if the exit was by the hold limit alone.
- Release precedence: `done`/`req` drop at the limit cycle counts as a normal release, with no `timeout`.
- TURN lasts exactly one cycle. It arbitrates as IDLE does, so a pending requester is granted at the edge ending TURN.
- `done` bits of non-owners, and `done` outside GRANT, are ignored.
- Counter width: $clog2(MAX_HOLD+1); it never wraps, because exit occurs at MAX_HOLD.

## Timing
- Request-to-grant latency from IDLE: `req` sampled at edge t, so `grant` is high from edge t. One cycle.
- Release: `done[owner]` sampled high at edge u, so `grant` is low from edge u.
- Handoff gap: exactly one cycle of `grant`=0 (TURN) between consecutive owners, including re-grant of the same requester.
- A requester that never releases receives exactly MAX_HOLD grant cycles, then TURN with `timeout`=1.
- All outputs are registered; no combinational path from `req`/`done` to any output.
- Reset asserted mid-GRANT drops `grant` and `bus_output_enable` immediately, without waiting for a clock edge.

## Structure
- Shared package `processor_pkg`: state encoding localparams (IDLE=2'd0, GRANT=2'd1, TURN=2'd2) and the default `MAX_HOLD`.
- One combinational sub-module, `rr_priority_picker`, takes (`req`, pointer) and returns (winner index, any). The FSM, hold counter and pointer stay in `bus_arbiter`.

## Test plan
- Reset then `req`=4'b0100 held, `done`[2] pulsed on the 3rd grant cycle: expect `grant`=4'b0100 for 3 cycles, then 1 cycle of 0, with `timeout`=0.
- `req`=4'b1111 held, each owner pulses `done` after 1 cycle: expect grant order 0,1,2,3,0 with a 1-cycle gap between each grant.
- `req`=4'b0001 held, no `done`, MAX_HOLD=8: expect exactly 8 cycles of `grant`=4'b0001, then TURN with `timeout`=1, then re-grant to 0.
- During owner 1's grant, `done`=4'b1000 (non-owner): expect no change. Then `req[1]` drops: expect `grant`=0 at that edge, pointer=2.
- `done[owner]` asserted on the MAX_HOLD-th cycle: expect normal release with `timeout`=0.
- Assert `resetn`=0 mid-grant between clock edges: expect `grant`=0 and `bus_output_enable`=0 immediately. After release, expect IDLE and pointer=0.
